// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array job sequencer.
package systolic_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StOutput,
        StDone
    } seq_state_e;

    // Skew flush of both edges plus the final MAC at the far corner PE.
    function automatic int unsigned drain_cyc(input int unsigned m, input int unsigned n,
                                              input int unsigned pe_lat);
        return m + n + pe_lat + 1;
    endfunction

    function automatic int unsigned idx_width(input int unsigned m, input int unsigned n);
        return (m * n > 1) ? $clog2(m * n) : 1;
    endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew.sv
// skew_line: DEPTH-stage delay line carrying data plus valid, with synchronous flush.
module skew_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     dat_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < int'(DEPTH); s++) dat_q[s] <= '0;
        end else if (flush) begin
            vld_q <= '0;
            for (int s = 0; s < int'(DEPTH); s++) dat_q[s] <= '0;
        end else begin
            vld_q[0] <= in_valid;
            // Invalid slots carry zero so downstream never sees stale operands.
            dat_q[0] <= in_valid ? in_data : '0;
            for (int s = 1; s < int'(DEPTH); s++) begin
                vld_q[s] <= vld_q[s-1];
                dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the MxN systolic MAC array: clear, skewed feed, drain, result readout.
// Optional SYSCTRL_ABORT_EN adds an abort input that forces DONE from any busy state.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned M      = 4,
    parameter int unsigned N      = 4,
    parameter int unsigned K_W    = 8,
    parameter int unsigned PE_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [K_W-1:0]              k_len,
    output logic                        busy,
    output logic                        done,
    output logic                        a_rd_en,
    output logic                        b_rd_en,
    output logic [K_W-1:0]              op_rd_addr,
    input  logic [M*DATA_W-1:0]         a_rd_data,
    input  logic [N*DATA_W-1:0]         b_rd_data,
    output logic                        arr_clear,
    output logic [M*DATA_W-1:0]         a_feed,
    output logic [M-1:0]                a_feed_valid,
    output logic [N*DATA_W-1:0]         b_feed,
    output logic [N-1:0]                b_feed_valid,
    input  logic [M*N*ACC_W-1:0]        acc_flat,
    output logic [ACC_W-1:0]            res_data,
    output logic [idx_width(M, N)-1:0]  res_idx,
    output logic                        res_valid,
`ifdef SYSCTRL_ABORT_EN
    input  logic                        abort,
`endif
    input  logic                        res_ready
);

    localparam int unsigned IDX_W     = idx_width(M, N);
    localparam int unsigned NRES      = M * N;
    localparam int unsigned DRAIN_CYC = drain_cyc(M, N, PE_LAT);
    localparam int unsigned DRAIN_W   = $clog2(DRAIN_CYC + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NRES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

    seq_state_e         state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [K_W-1:0]     feed_cnt_q, feed_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               rd_en_q;
    logic               abort_req;
    logic [ACC_W-1:0]   acc_arr [NRES];

`ifdef SYSCTRL_ABORT_EN
    assign abort_req = abort && (state_q != StIdle);
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            feed_cnt_q  <= '0;
            drain_cnt_q <= '0;
            idx_q       <= '0;
            rd_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            feed_cnt_q  <= feed_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            idx_q       <= idx_d;
            // Buffer data lands one cycle after the strobe; this marks it valid.
            rd_en_q     <= (state_q == StFeed) && !abort_req;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        feed_cnt_d  = feed_cnt_q;
        drain_cnt_d = drain_cnt_q;
        idx_d       = idx_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    k_d     = k_len;
                    state_d = StClear;
                end
            end
            StClear: begin
                feed_cnt_d  = '0;
                drain_cnt_d = '0;
                idx_d       = '0;
                state_d     = (k_q == '0) ? StOutput : StFeed;
            end
            StFeed: begin
                feed_cnt_d = feed_cnt_q + 1'b1;
                if (feed_cnt_q == k_q - 1'b1) state_d = StDrain;
            end
            StDrain: begin
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q == DRAIN_LAST) state_d = StOutput;
            end
            StOutput: begin
                if (res_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort_req) state_d = StDone;
    end

    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign arr_clear  = (state_q == StClear);
    assign a_rd_en    = (state_q == StFeed);
    assign b_rd_en    = (state_q == StFeed);
    assign op_rd_addr = (state_q == StFeed) ? feed_cnt_q : '0;

    for (genvar p = 0; p < NRES; p++) begin : g_acc
        assign acc_arr[p] = acc_flat[p*ACC_W +: ACC_W];
    end

    assign res_valid = (state_q == StOutput);
    assign res_idx   = res_valid ? idx_q : '0;
    assign res_data  = res_valid ? acc_arr[idx_q] : '0;

    for (genvar i = 0; i < M; i++) begin : g_row
        skew_line #(
            .DEPTH (i + 1),
            .W     (DATA_W)
        ) u_skew (
            .clk       (clk),
            .rst       (rst),
            .flush     (abort_req),
            .in_valid  (rd_en_q),
            .in_data   (a_rd_data[i*DATA_W +: DATA_W]),
            .out_valid (a_feed_valid[i]),
            .out_data  (a_feed[i*DATA_W +: DATA_W])
        );
    end

    for (genvar j = 0; j < N; j++) begin : g_col
        skew_line #(
            .DEPTH (j + 1),
            .W     (DATA_W)
        ) u_skew (
            .clk       (clk),
            .rst       (rst),
            .flush     (abort_req),
            .in_valid  (rd_en_q),
            .in_data   (b_rd_data[j*DATA_W +: DATA_W]),
            .out_valid (b_feed_valid[j]),
            .out_data  (b_feed[j*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Scoreboard bench for systolic_seq_ctrl: random jobs, matrix-product reference, timing checks.
module tb_systolic_seq_ctrl;

    localparam int M      = 4;
    localparam int N      = 4;
    localparam int DW     = 8;
    localparam int AW     = 32;
    localparam int KW     = 8;
    localparam int PE_LAT = 1;
    localparam int NRES   = M * N;
    localparam int IW     = 4;
    localparam int MAXK   = 16;
    localparam int DRAIN  = M + N + PE_LAT + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [KW-1:0]     k_len;
    logic              busy, done, a_rd_en, b_rd_en, arr_clear, res_valid, res_ready;
    logic [KW-1:0]     op_rd_addr;
    logic [M*DW-1:0]   a_rd_data = '0;
    logic [N*DW-1:0]   b_rd_data = '0;
    logic [M*DW-1:0]   a_feed;
    logic [M-1:0]      a_feed_valid;
    logic [N*DW-1:0]   b_feed;
    logic [N-1:0]      b_feed_valid;
    logic [M*N*AW-1:0] acc_flat;
    logic [AW-1:0]     res_data;
    logic [IW-1:0]     res_idx;
`ifdef SYSCTRL_ABORT_EN
    logic              abort;
`endif

    systolic_seq_ctrl #(
        .DATA_W (DW),
        .ACC_W  (AW),
        .M      (M),
        .N      (N),
        .K_W    (KW),
        .PE_LAT (PE_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_len        (k_len),
        .busy         (busy),
        .done         (done),
        .a_rd_en      (a_rd_en),
        .b_rd_en      (b_rd_en),
        .op_rd_addr   (op_rd_addr),
        .a_rd_data    (a_rd_data),
        .b_rd_data    (b_rd_data),
        .arr_clear    (arr_clear),
        .a_feed       (a_feed),
        .a_feed_valid (a_feed_valid),
        .b_feed       (b_feed),
        .b_feed_valid (b_feed_valid),
        .acc_flat     (acc_flat),
        .res_data     (res_data),
        .res_idx      (res_idx),
        .res_valid    (res_valid),
`ifdef SYSCTRL_ABORT_EN
        .abort        (abort),
`endif
        .res_ready    (res_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Operand buffers: column A[:,k] and row B[k,:], one cycle read latency.
    logic [DW-1:0] amat [M][MAXK];
    logic [DW-1:0] bmat [MAXK][N];

    always @(posedge clk) begin
        for (int i = 0; i < M; i++)
            if (a_rd_en) a_rd_data[i*DW +: DW] <= amat[i][op_rd_addr[3:0]];
        for (int j = 0; j < N; j++)
            if (b_rd_en) b_rd_data[j*DW +: DW] <= bmat[op_rd_addr[3:0]][j];
    end

    // Array model: each PE(i,j) accumulates the pairwise products of the element
    // streams seen on row i and column j since the last clear.
    logic [DW-1:0] rs [M][MAXK];
    logic [DW-1:0] cs [N][MAXK];
    int            rlen [M];
    int            clen [N];

    always @(posedge clk or posedge rst) begin
        if (rst || arr_clear) begin
            for (int i = 0; i < M; i++) rlen[i] <= 0;
            for (int j = 0; j < N; j++) clen[j] <= 0;
        end else begin
            for (int i = 0; i < M; i++)
                if (a_feed_valid[i] && rlen[i] < MAXK) begin
                    rs[i][rlen[i]] <= a_feed[i*DW +: DW];
                    rlen[i]        <= rlen[i] + 1;
                end
            for (int j = 0; j < N; j++)
                if (b_feed_valid[j] && clen[j] < MAXK) begin
                    cs[j][clen[j]] <= b_feed[j*DW +: DW];
                    clen[j]        <= clen[j] + 1;
                end
        end
    end

    always_comb begin
        acc_flat = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                for (int n = 0; n < MAXK; n++)
                    if (n < rlen[i] && n < clen[j])
                        acc_flat[(i*N+j)*AW +: AW] = acc_flat[(i*N+j)*AW +: AW]
                                                     + AW'(rs[i][n]) * AW'(cs[j][n]);
    end

    typedef struct {
        logic [AW-1:0] data;
        int            idx;
    } exp_t;
    exp_t exp_q [$];

    // Job context written by the driver, read by the monitor.
    int  job_id = 0;
    bit  job_active = 0;
    bit  mon_en = 0;
    int  t_start, cur_k, exp_first, exp_done;
    int  ready_mode = 0;
    int  done_events = 0;

    initial begin
        int rphase;
        rphase    = 0;
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       res_ready = 1'b1;
                1:       begin res_ready = (rphase % 3 == 0); rphase++; end
                default: res_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor
    int            mon_job = 0;
    int            clr_cnt, rd_cnt;
    int            first_a [M], last_a [M], cnt_a [M];
    int            first_b [N], last_b [N], cnt_b [N];
    bit            seen_res, stalled;
    logic [AW-1:0] last_data;
    logic [IW-1:0] last_idx;

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (job_id != mon_job) begin
                mon_job  = job_id;
                clr_cnt  = 0;
                rd_cnt   = 0;
                seen_res = 0;
                stalled  = 0;
                for (int i = 0; i < M; i++) begin first_a[i] = -1; last_a[i] = -1; cnt_a[i] = 0; end
                for (int j = 0; j < N; j++) begin first_b[j] = -1; last_b[j] = -1; cnt_b[j] = 0; end
            end
            if (!job_active) begin
                chk("stale_res_valid", res_valid, 0);
                chk("stale_feed_valid", {a_feed_valid, b_feed_valid}, 0);
            end else begin
                if (arr_clear) begin
                    clr_cnt++;
                    chk("clear_cycle", cyc, t_start + 1);
                end
                chk("b_rd_en_match", b_rd_en, a_rd_en);
                if (a_rd_en) begin
                    chk("rd_addr", op_rd_addr, rd_cnt);
                    rd_cnt++;
                end
                for (int i = 0; i < M; i++) begin
                    if (a_feed_valid[i]) begin
                        if (first_a[i] < 0) first_a[i] = cyc;
                        last_a[i] = cyc;
                        cnt_a[i]++;
                    end else chk("a_feed_idle_zero", a_feed[i*DW +: DW], 0);
                end
                for (int j = 0; j < N; j++) begin
                    if (b_feed_valid[j]) begin
                        if (first_b[j] < 0) first_b[j] = cyc;
                        last_b[j] = cyc;
                        cnt_b[j]++;
                    end else chk("b_feed_idle_zero", b_feed[j*DW +: DW], 0);
                end
                if (res_valid) begin
                    if (!seen_res) begin
                        seen_res = 1;
                        chk("first_res_cycle", cyc, exp_first);
                    end
                    if (stalled) begin
                        chk("stall_data_stable", res_data, last_data);
                        chk("stall_idx_stable", res_idx, last_idx);
                    end
                    if (res_ready) begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL extra_result: got idx %0d data %0d, want none", res_idx, res_data);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            chk("res_data", res_data, e.data);
                            chk("res_idx", res_idx, e.idx);
                        end
                    end
                    stalled   = !res_ready;
                    last_data = res_data;
                    last_idx  = res_idx;
                end else stalled = 0;
                if (done) begin
                    if (ready_mode == 0) chk("done_cycle", cyc, exp_done);
                    chk("results_missing", exp_q.size(), 0);
                    chk("clear_pulses", clr_cnt, 1);
                    chk("rd_strobes", rd_cnt, cur_k);
                    for (int i = 0; i < M; i++) begin
                        chk("a_valid_len", cnt_a[i], cur_k);
                        if (cur_k > 0) begin
                            chk("a_valid_first", first_a[i], t_start + 4 + i);
                            chk("a_valid_contig", last_a[i] - first_a[i], cur_k - 1);
                        end
                    end
                    for (int j = 0; j < N; j++) begin
                        chk("b_valid_len", cnt_b[j], cur_k);
                        if (cur_k > 0) begin
                            chk("b_valid_first", first_b[j], t_start + 4 + j);
                            chk("b_valid_contig", last_b[j] - first_b[j], cur_k - 1);
                        end
                    end
                    done_events++;
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_en"}, {a_rd_en, b_rd_en}, 0);
        chk({tag, "_arr_clear"}, arr_clear, 0);
        chk({tag, "_feed_valid"}, {a_feed_valid, b_feed_valid}, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_op_rd_addr"}, op_rd_addr, 0);
        chk({tag, "_a_feed"}, a_feed, 0);
        chk({tag, "_b_feed"}, b_feed, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_idx"}, res_idx, 0);
    endtask

    // pat 0: random operands, 1: all ones, 2: a = k+2, b = k+3
    task automatic run_job(input int k, input int pat, input int rmode);
        int            ev0;
        logic [AW-1:0] s;
        for (int i = 0; i < M; i++)
            for (int kk = 0; kk < MAXK; kk++)
                amat[i][kk] = (pat == 0) ? 8'($urandom_range(0, 255)) :
                              (pat == 1) ? 8'd1 : 8'(kk + 2);
        for (int kk = 0; kk < MAXK; kk++)
            for (int j = 0; j < N; j++)
                bmat[kk][j] = (pat == 0) ? 8'($urandom_range(0, 255)) :
                              (pat == 1) ? 8'd1 : 8'(kk + 3);
        exp_q.delete();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int kk = 0; kk < k; kk++) s = s + AW'(amat[i][kk]) * AW'(bmat[kk][j]);
                exp_q.push_back('{data: s, idx: i * N + j});
            end
        ev0 = done_events;
        @(posedge clk);
        #1;
        ready_mode = rmode;
        start      = 1'b1;
        k_len      = KW'(k);
        t_start    = cyc;
        cur_k      = k;
        exp_first  = (k == 0) ? t_start + 2 : t_start + 2 + k + DRAIN;
        exp_done   = exp_first + NRES;
        job_id++;
        job_active = 1;
        // While busy, start and k_len are scrambled: both must be ignored.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            if (done_events != ev0) break;
            #1;
            start = 1'($urandom_range(0, 1));
            k_len = KW'($urandom);
        end
        #1;
        start      = 1'b0;
        job_active = 0;
        if (done_events == ev0) begin
            n_cmp++;
            n_err++;
            $display("FAIL job_timeout: got no done within 3000 cycles, want done (k=%0d)", k);
        end
        @(negedge clk);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, want finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        start = 1'b0;
        k_len = '0;
        rst   = 1'b1;
`ifdef SYSCTRL_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1;

        run_job(4, 1, 0);
        run_job(5, 2, 0);
        run_job(3, 0, 0);
        run_job(3, 0, 1);
        run_job(0, 0, 0);

        // Reset in the middle of FEED, then a fresh job.
        mon_en = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        k_len = 8'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_rd_en) break;
        end
        chk("feed_reached", a_rd_en, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("mid_feed_reset");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1;
        run_job(2, 0, 0);

`ifdef SYSCTRL_ABORT_EN
        begin
            int ta;
            mon_en = 0;
            @(posedge clk);
            #1;
            start = 1'b1;
            k_len = 8'd3;
            ta    = cyc;
            @(posedge clk);
            #1;
            start = 1'b0;
            while (cyc < ta + 9) @(posedge clk);
            #1;
            abort = 1'b1;
            @(negedge clk);
            chk("abort_no_early_done", done, 0);
            @(posedge clk);
            #1;
            abort = 1'b0;
            @(negedge clk);
            chk("abort_done", done, 1);
            chk("abort_res_valid", res_valid, 0);
            chk("abort_feed_flushed", {a_feed_valid, b_feed_valid}, 0);
            @(negedge clk);
            chk("abort_idle", busy, 0);
            chk("abort_single_done", done, 0);
            mon_en = 1;
        end
`endif

        for (int r = 0; r < 4; r++) run_job($urandom_range(1, 12), 0, $urandom_range(0, 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
